// File: rtl/msg_addr_sequencer.sv
// Purpose: read-address sequencer for the SHA-256 message buffer (base, length, up/down, wrap).
// Latency: first address valid the cycle after an accepted start; completion pulse one cycle after the last handshake.
// Backpressure: addr_ready low holds address and count; abort cancels without a completion pulse.
module msg_addr_sequencer #(
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  count_down,
  input  logic                  abort,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  addr_valid,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  words_remaining,
  output logic                  read_complete
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [LEN_WIDTH-1:0]  rem_q, rem_nxt;
  logic                  dir_q, dir_nxt;

  // State and datapath registers; reset wins over any in-flight request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      addr_q  <= addr_nxt;
      rem_q   <= rem_nxt;
      dir_q   <= dir_nxt;
    end
  end

  // Next-state and datapath update: abort beats start/handshake, last handshake ends the run
  // without stepping the address so it keeps showing the final word issued.
  always_comb begin
    state_nxt = state_q;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    dir_nxt   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          addr_nxt  = base_addr;
          rem_nxt   = length;
          dir_nxt   = count_down;
          state_nxt = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
          rem_nxt   = '0;
        end else if (addr_ready) begin
          if (rem_q == LEN_WIDTH'(1)) begin
            state_nxt = S_DONE;
            rem_nxt   = '0;
          end else begin
            addr_nxt = dir_q ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
            rem_nxt  = rem_q - LEN_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registered state; no input-to-output path.
  always_comb begin
    read_address    = addr_q;
    words_remaining = rem_q;
    addr_valid      = (state_q == S_RUN);
    busy            = (state_q != S_IDLE);
    read_complete   = (state_q == S_DONE);
  end

endmodule

// File: doc/msg_addr_sequencer.md
# msg_addr_sequencer

Parametrised read-address sequencer for the message buffer feeding the SHA-256 message schedule. On a start pulse it captures a base address, word count and direction, then issues one address per accepted valid/ready handshake, wrapping modulo the address space. It supports back-pressure, abort, zero-length requests and a one-cycle completion pulse. It is the successor to the fixed-length up-counter in the message read path.

## Interface
- ADDR_WIDTH, 6: width of read_address; addresses wrap modulo 2^ADDR_WIDTH.
- LEN_WIDTH, 7: width of length and words_remaining; max request is 2^LEN_WIDTH-1 words.
- clock  input  1  clock, all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; accepted only in IDLE.
- base_addr  input  ADDR_WIDTH  first address; sampled with accepted start.
- length  input  LEN_WIDTH  number of words to issue; sampled with accepted start.
- count_down  input  1  0 = increment per word, 1 = decrement; sampled with accepted start.
- abort  input  1  cancel active request; returns to IDLE with no completion pulse.
- addr_ready  input  1  consumer accepts read_address this cycle when addr_valid=1.
- read_address  output  ADDR_WIDTH  current address.
- addr_valid  output  1  read_address valid (RUN state).
- busy  output  1  high in RUN and DONE.
- words_remaining  output  LEN_WIDTH  words not yet handshaken.
- read_complete  output  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE; read_address=0, addr_valid=0, busy=0, words_remaining=0, read_complete=0. Reset overrides everything, including mid-request.
- Transitions:
  - IDLE + start + !abort + length≠0 -> RUN. Captures read_address=base_addr, words_remaining=length and direction.
  - IDLE + start + !abort + length=0 -> DONE. Captures read_address=base_addr, words_remaining=0.
  - IDLE + abort: stay IDLE; abort beats start.
  - RUN + abort -> IDLE. abort wins over a same-cycle handshake; the address does not advance and words_remaining clears to 0.
  - RUN + handshake (addr_valid & addr_ready) with words_remaining=1 -> DONE; words_remaining becomes 0.
  - RUN + handshake otherwise: read_address ±1 (mod 2^ADDR_WIDTH), words_remaining −1.
  - RUN without handshake: hold all state.
  - DONE -> IDLE unconditionally. abort in DONE is ignored; the completion pulse still occurs.
- start while busy is ignored; it is never queued.
- read_address holds its last value in DONE and IDLE until the next accepted start.
- Wrap: incrementing from 2^ADDR_WIDTH−1 gives 0; decrementing from 0 gives 2^ADDR_WIDTH−1. Wrap is not an error.
- Outputs decode from registered state. No combinational path from inputs to outputs.

## Timing
- start accepted at edge E (state IDLE): from E+1, addr_valid=1 and read_address=base_addr.
- With addr_ready held high and length L: addr_valid is high for cycles E+1..E+L, read_complete at E+L+1, IDLE at E+L+2. The earliest next accepted start is sampled at edge E+L+2.
- length=0: read_complete at E+1, IDLE at E+2; addr_valid is never asserted.
- Each cycle with addr_ready=0 in RUN stretches the sequence by exactly one cycle.
- abort sampled at edge A in RUN: addr_valid=0 and busy=0 from A+1; read_complete never pulses.
- busy=1 for every cycle in RUN and DONE.

## Test plan
- Reset, then start with base_addr=5, length=4, count_down=0, addr_ready=1 -> addresses 5,6,7,8 on 4 consecutive valid cycles, read_complete on the 5th cycle, busy low on the 6th.
- base_addr=62, length=4, count_down=0 (ADDR_WIDTH=6) -> 62,63,0,1. Then base_addr=1, length=3, count_down=1 -> 1,0,63.
- length=6 with addr_ready low on every other cycle -> each address held while ready=0, 11 valid cycles total, words_remaining 6→0, exactly one read_complete.
- length=0 -> addr_valid never high; read_complete one cycle after start; a start asserted during DONE is ignored.
- length=10, abort after the 3rd handshake, then a second start the same cycle as abort in IDLE -> no read_complete, IDLE and words_remaining=0 after abort, second start ignored. Separately, reset mid-RUN -> all outputs 0 next cycle.
